dual_beam_trigger_scaler: RTL and testbench

Downstream consumer of the dual-beam threshold DSP's 2-bit `trigger_o`. Per beam, it turns the raw trigger level into single-cycle qualified pulses with rising-edge detection and a programmable holdoff, and counts accepted pulses over a fixed gate period. At the end of each period it publishes a snapshot of both beam rates through a valid/ack handshake for the register readout.

---
 rtl/dual_beam_trigger_scaler.sv | 125 ++++++++++++
 tb/tb_dual_beam_trigger_scaler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_beam_trigger_scaler.sv
// dual_beam_trigger_scaler
// Turns the 2-bit raw trigger level from the DSP stage into single-cycle
// qualified pulses per beam (rising-edge detect plus programmable holdoff).
// Accepted pulses are counted over a fixed gate period, and each period's
// counts are published as a snapshot through a valid/ack handshake.
// Optional build macro PUEO_SCALER_SATURATE_EN: when defined, the
// accumulators saturate at all-ones instead of wrapping.

module dual_beam_trigger_scaler #(
  parameter int COUNT_WIDTH  = 16,
  parameter int PERIOD_CLKS  = 200000,
  parameter int HOLDOFF_CLKS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [1:0]             trigger_i,
  output logic [1:0]             trig_o,
  output logic [COUNT_WIDTH-1:0] scalerA_o,
  output logic [COUNT_WIDTH-1:0] scalerB_o,
  output logic                   scaler_valid_o,
  input  logic                   scaler_ack_i,
  output logic                   scaler_lost_o
);

  localparam int PW = $clog2(PERIOD_CLKS);
  localparam int HW = (HOLDOFF_CLKS < 1) ? 1 : $clog2(HOLDOFF_CLKS + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CLKS - 1);
  localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(HOLDOFF_CLKS);

  logic [1:0]             trig_q;
  logic [1:0][HW-1:0]     ho;
  logic [1:0]             accept;
  logic [PW-1:0]          period_cnt;
  logic                   terminal;
  logic [COUNT_WIDTH-1:0] acc_a;
  logic [COUNT_WIDTH-1:0] acc_b;
  logic [COUNT_WIDTH:0]   sum_a;
  logic [COUNT_WIDTH:0]   sum_b;
  logic [COUNT_WIDTH-1:0] next_a;
  logic [COUNT_WIDTH-1:0] next_b;

  // A rising edge is accepted only when that beam's holdoff has expired
  always_comb begin
    accept = 2'b00;
    for (int k = 0; k < 2; k++) begin
      accept[k] = trigger_i[k] & ~trig_q[k] & (ho[k] == '0);
    end
  end

  assign terminal = enable_i && (period_cnt == PERIOD_LAST);

  // Next accumulator values: current count plus this cycle's accepted pulse
  always_comb begin
    sum_a = {1'b0, acc_a} + {{COUNT_WIDTH{1'b0}}, accept[0]};
    sum_b = {1'b0, acc_b} + {{COUNT_WIDTH{1'b0}}, accept[1]};
`ifdef PUEO_SCALER_SATURATE_EN
    next_a = sum_a[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : sum_a[COUNT_WIDTH-1:0];
    next_b = sum_b[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : sum_b[COUNT_WIDTH-1:0];
`else
    next_a = sum_a[COUNT_WIDTH-1:0];
    next_b = sum_b[COUNT_WIDTH-1:0];
`endif
  end

  // Edge-detect history, holdoff down-counters and the qualified pulse outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_q <= 2'b00;
      ho     <= '0;
      trig_o <= 2'b00;
    end else begin
      trig_q <= trigger_i;
      trig_o <= accept;
      for (int k = 0; k < 2; k++) begin
        if (accept[k]) begin
          ho[k] <= HOLDOFF_LOAD;
        end else if (ho[k] != '0) begin
          ho[k] <= ho[k] - HW'(1);
        end
      end
    end
  end

  // Gate-period counter and per-beam accumulators, held at zero while disabled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_cnt <= '0;
      acc_a      <= '0;
      acc_b      <= '0;
    end else if (!enable_i || terminal) begin
      period_cnt <= '0;
      acc_a      <= '0;
      acc_b      <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
      acc_a      <= next_a;
      acc_b      <= next_b;
    end
  end

  // Snapshot publication with valid/ack handshake and sticky overwrite flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scalerA_o      <= '0;
      scalerB_o      <= '0;
      scaler_valid_o <= 1'b0;
      scaler_lost_o  <= 1'b0;
    end else begin
      if (terminal) begin
        scalerA_o      <= next_a;
        scalerB_o      <= next_b;
        scaler_valid_o <= 1'b1;
      end else if (scaler_ack_i && scaler_valid_o) begin
        scaler_valid_o <= 1'b0;
      end
      if (terminal && scaler_valid_o && !scaler_ack_i) begin
        scaler_lost_o <= 1'b1;
      end else if (scaler_valid_o && scaler_ack_i) begin
        scaler_lost_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_beam_trigger_scaler.sv
// tb_dual_beam_trigger_scaler
// Directed bench for dual_beam_trigger_scaler with PERIOD_CLKS=100,
// HOLDOFF_CLKS=4, COUNT_WIDTH=4. Expected pulses and snapshots are queued
// as stimulus is issued; a negedge monitor pops and compares them.

module tb_dual_beam_trigger_scaler;

  localparam int COUNT_WIDTH  = 4;
  localparam int PERIOD_CLKS  = 100;
  localparam int HOLDOFF_CLKS = 4;

  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic [1:0]             trigger;
  logic [1:0]             trig;
  logic [COUNT_WIDTH-1:0] scaler_a;
  logic [COUNT_WIDTH-1:0] scaler_b;
  logic                   scaler_valid;
  logic                   scaler_ack;
  logic                   scaler_lost;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int base;
  int base2;
  int sat_b;
  logic valid_prev = 1'b0;

  int exp_trig_cyc[$];
  int exp_trig_bits[$];
  int exp_snap_cyc[$];
  int exp_snap_a[$];
  int exp_snap_b[$];

  dual_beam_trigger_scaler #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .PERIOD_CLKS (PERIOD_CLKS),
    .HOLDOFF_CLKS(HOLDOFF_CLKS)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .trigger_i     (trigger),
    .trig_o        (trig),
    .scalerA_o     (scaler_a),
    .scalerB_o     (scaler_b),
    .scaler_valid_o(scaler_valid),
    .scaler_ack_i  (scaler_ack),
    .scaler_lost_o (scaler_lost)
  );

  // Free-running clock, first rising edge at 5 ns
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench edge counter used to timestamp every expected event
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Advance to 1 ns after rising edge number c
  task automatic goTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int at, input int beam, input logic level);
    goTo(at);
    trigger[beam] = level;
  endtask

  // One-cycle raw pulse; if it should be accepted, queue the qualified pulse
  task automatic pulseBeam(input int at, input int beam, input bit expect_accept);
    if (expect_accept) begin
      exp_trig_cyc.push_back(at + 1);
      exp_trig_bits.push_back(1 << beam);
    end
    applyStimulus(at, beam, 1'b1);
    applyStimulus(at + 1, beam, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_trig"}, int'(trig), 0);
    checkOutput({tag, "_scalerA"}, int'(scaler_a), 0);
    checkOutput({tag, "_scalerB"}, int'(scaler_b), 0);
    checkOutput({tag, "_valid"}, int'(scaler_valid), 0);
    checkOutput({tag, "_lost"}, int'(scaler_lost), 0);
  endtask

  // Monitor: compares qualified pulses and new snapshots against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (trig != 2'b00) begin
        if (exp_trig_cyc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_trig: got %0d at cycle %0d, expected none", trig, cyc);
        end else begin
          checkOutput("trig_cycle", cyc, exp_trig_cyc.pop_front());
          checkOutput("trig_bits", int'(trig), exp_trig_bits.pop_front());
        end
      end
      if (scaler_valid && !valid_prev) begin
        if (exp_snap_cyc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_snapshot: got A=%0d B=%0d at cycle %0d, expected none",
                   scaler_a, scaler_b, cyc);
        end else begin
          checkOutput("snap_cycle", cyc, exp_snap_cyc.pop_front());
          checkOutput("snap_A", int'(scaler_a), exp_snap_a.pop_front());
          checkOutput("snap_B", int'(scaler_b), exp_snap_b.pop_front());
        end
      end
    end
    valid_prev = scaler_valid;
  end

  // Watchdog so the run always ends with a summary
  initial begin
    #100000;
    n_checks++;
    n_fail++;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Directed stimulus sequence
  initial begin
`ifdef PUEO_SCALER_SATURATE_EN
    sat_b = 15;
`else
    sat_b = 4;
`endif
    rst        = 1'b0;
    enable     = 1'b0;
    trigger    = 2'b00;
    scaler_ack = 1'b0;
    #1 rst = 1'b1;
    #1 checkAllZero("reset_initial");

    goTo(3);
    rst    = 1'b0;
    enable = 1'b1;
    base   = cyc;

    // Period 1: three isolated A pulses, B held high for 50 clocks
    exp_snap_cyc.push_back(base + 100);
    exp_snap_a.push_back(3);
    exp_snap_b.push_back(1);
    pulseBeam(base + 10, 0, 1'b1);
    pulseBeam(base + 20, 0, 1'b1);
    pulseBeam(base + 30, 0, 1'b1);
    exp_trig_cyc.push_back(base + 41);
    exp_trig_bits.push_back(2);
    applyStimulus(base + 40, 1, 1'b1);
    applyStimulus(base + 90, 1, 1'b0);

    // Period 2: A toggles every cycle, only edges 1, 4, 7, 10 survive holdoff
    for (int i = 0; i < 10; i++) begin
      pulseBeam(base + 110 + 2 * i, 0, (i == 0 || i == 3 || i == 6 || i == 9));
    end
    goTo(base + 150);
    checkOutput("valid_after_snap1", int'(scaler_valid), 1);
    checkOutput("lost_before_snap2", int'(scaler_lost), 0);

    // Snapshot 2 overwrites unacked snapshot 1
    goTo(base + 200);
    checkOutput("snap2_valid", int'(scaler_valid), 1);
    checkOutput("snap2_lost", int'(scaler_lost), 1);
    checkOutput("snap2_A", int'(scaler_a), 4);
    checkOutput("snap2_B", int'(scaler_b), 0);

    // Period 3: 20 spaced B pulses, plus an A pulse in the terminal cycle
    for (int i = 0; i < 20; i++) begin
      pulseBeam(base + 200 + 5 * i, 1, 1'b1);
    end
    goTo(base + 299);
    exp_trig_cyc.push_back(base + 300);
    exp_trig_bits.push_back(1);
    trigger[0] = 1'b1;
    scaler_ack = 1'b1;
    goTo(base + 300);
    trigger[0] = 1'b0;
    scaler_ack = 1'b0;
    checkOutput("snap3_valid", int'(scaler_valid), 1);
    checkOutput("snap3_lost", int'(scaler_lost), 0);
    checkOutput("snap3_A_terminal", int'(scaler_a), 1);
    checkOutput("snap3_B_overflow", int'(scaler_b), sat_b);

    goTo(base + 301);
    scaler_ack = 1'b1;
    goTo(base + 302);
    scaler_ack = 1'b0;
    checkOutput("ack_clears_valid", int'(scaler_valid), 0);
    checkOutput("ack_lost", int'(scaler_lost), 0);

    // Period 4: enable dropped for 30 clocks, fresh period after re-enable
    exp_snap_cyc.push_back(base + 450);
    exp_snap_a.push_back(1);
    exp_snap_b.push_back(0);
    pulseBeam(base + 310, 0, 1'b1);
    goTo(base + 320);
    enable = 1'b0;
    pulseBeam(base + 330, 1, 1'b1);
    goTo(base + 350);
    enable = 1'b1;
    pulseBeam(base + 360, 0, 1'b1);
    goTo(base + 400);
    checkOutput("no_snap_in_gap", int'(scaler_valid), 0);

    // Period 5: reset mid-period with a pulse in flight
    pulseBeam(base + 460, 1, 1'b1);
    applyStimulus(base + 470, 0, 1'b1);
    goTo(base + 471);
    checkOutput("inflight_trig", int'(trig), 1);
    rst     = 1'b1;
    trigger = 2'b00;
    #1 checkAllZero("reset_midperiod");

    goTo(base + 475);
    rst   = 1'b0;
    base2 = cyc;
    exp_snap_cyc.push_back(base2 + 100);
    exp_snap_a.push_back(0);
    exp_snap_b.push_back(1);
    pulseBeam(base2 + 5, 1, 1'b1);
    goTo(base2 + 105);

    checkOutput("trig_queue_drained", exp_trig_cyc.size(), 0);
    checkOutput("snap_queue_drained", exp_snap_cyc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
